// File: rtl/vga_timing_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_gen_if
// Description : Pixel timing bundle from the VGA timing generator to its sinks.
// Revision    : 1.0 - initial release
// ============================================================================
interface vga_timing_gen_if;
    logic        p_tick;
    logic [10:0] x;
    logic [9:0]  y;
    logic        video_on;
    logic        hsync;
    logic        vsync;
    logic        vblank_tick;

    modport master (
        output p_tick, x, y, video_on, hsync, vsync, vblank_tick
    );

    modport slave (
        input  p_tick, x, y, video_on, hsync, vsync, vblank_tick
    );
endinterface
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_gen
// Description : 640x480@60 VGA timing: pixel tick, x/y counters, sync pulses,
//               visible-area flag and a once-per-frame vertical-blank pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
    parameter int CLK_DIV   = 4,
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic             clk,
    input  logic             reset,
    vga_timing_gen_if.master vga
);

    localparam int c_tw = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [c_tw-1:0] c_tick_last = c_tw'(CLK_DIV - 1);
    localparam logic [10:0] c_h_last     = 11'(H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [10:0] c_h_display  = 11'(H_DISPLAY);
    localparam logic [10:0] c_hs_start   = 11'(H_DISPLAY + H_FRONT);
    localparam logic [10:0] c_hs_end     = 11'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [9:0]  c_v_last     = 10'(V_DISPLAY + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [9:0]  c_v_display  = 10'(V_DISPLAY);
    localparam logic [9:0]  c_v_vis_last = 10'(V_DISPLAY - 1);
    localparam logic [9:0]  c_vs_start   = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0]  c_vs_end     = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    logic [c_tw-1:0] r_tick;
    logic [10:0]     r_h;
    logic [9:0]      r_v;
    logic            r_hsync;
    logic            r_vsync;

    logic            w_p_tick;
    logic [10:0]     w_h_next;
    logic [9:0]      w_v_next;

    assign w_p_tick = (r_tick == c_tick_last);

    always_comb begin
        w_h_next = r_h;
        w_v_next = r_v;
        if (w_p_tick) begin
            if (r_h == c_h_last) begin
                w_h_next = 11'd0;
                w_v_next = (r_v == c_v_last) ? 10'd0 : r_v + 10'd1;
            end else begin
                w_h_next = r_h + 11'd1;
            end
        end
    end

    // Syncs are decoded from the next counter values so they switch on the
    // same edge as the x/y they belong to.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tick  <= '0;
            r_h     <= 11'd0;
            r_v     <= 10'd0;
            r_hsync <= 1'b1;
            r_vsync <= 1'b1;
        end else begin
            r_tick  <= w_p_tick ? '0 : r_tick + c_tw'(1);
            r_h     <= w_h_next;
            r_v     <= w_v_next;
            r_hsync <= !((w_h_next >= c_hs_start) && (w_h_next <= c_hs_end));
            r_vsync <= !((w_v_next >= c_vs_start) && (w_v_next <= c_vs_end));
        end
    end

    assign vga.p_tick      = w_p_tick;
    assign vga.x           = r_h;
    assign vga.y           = r_v;
    assign vga.video_on    = (r_h < c_h_display) && (r_v < c_v_display);
    assign vga.hsync       = r_hsync;
    assign vga.vsync       = r_vsync;
    assign vga.vblank_tick = w_p_tick && (r_h == c_h_last) && (r_v == c_v_vis_last);

endmodule
`default_nettype wire

// File: doc/vga_timing_gen.md
# vga_timing_gen

Generates 640x480@60 Hz VGA timing from the 100 MHz system clock: pixel-enable tick, horizontal/vertical counters, active-low sync pulses and a visible-area flag. Its x/y outputs are the pixel coordinates consumed by every sprite display unit. Its hsync/vsync drive the VGA connector. It also emits a once-per-frame vertical-blank pulse, which game logic uses to update object positions.

## Interface
- CLK_DIV, 4: system clocks per pixel (100 MHz / 4 = 25 MHz pixel rate)
- H_DISPLAY, 640: visible pixels per line
- H_FRONT, 16: horizontal front porch, pixels
- H_SYNC, 96: hsync pulse width, pixels
- H_BACK, 48: horizontal back porch, pixels
- V_DISPLAY, 480: visible lines per frame
- V_FRONT, 10: vertical front porch, lines
- V_SYNC, 2: vsync pulse width, lines
- V_BACK, 33: vertical back porch, lines

Ports:
- clk  in  1  system clock, 100 MHz
- reset  in  1  asynchronous, active-high
- p_tick  out  1  one-clk pixel-enable pulse
- x  out  11  current pixel column (h_count)
- y  out  10  current pixel row (v_count)
- video_on  out  1  high when x < H_DISPLAY and y < V_DISPLAY
- hsync  out  1  horizontal sync, active-low
- vsync  out  1  vertical sync, active-low
- vblank_tick  out  1  one-clk pulse at entry to vertical blank

## Operation
- Derived constants: H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK = 800; V_TOTAL = 525.
- Tick counter: counts 0..CLK_DIV-1 and wraps.
  - p_tick is combinational: high exactly when tick counter == CLK_DIV-1.
- Horizontal counter: advances only on cycles with p_tick.
  - At H_TOTAL-1 it wraps to 0, and the vertical counter advances in the same cycle.
- Vertical counter: wraps from V_TOTAL-1 to 0.
- Counters never exceed TOTAL-1. x and y are the counter registers directly.
- hsync: registered. Low when the (next) h_count is in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1], i.e. x = 656..751.
- vsync: registered. Low when the (next) v_count is in [V_DISPLAY+V_FRONT, V_DISPLAY+V_FRONT+V_SYNC-1], i.e. y = 490..491.
- hsync/vsync are computed from next-state counter values, so they are aligned with the x/y they describe and glitch-free.
- video_on: combinational from the counter registers.
- vblank_tick: combinational; high when p_tick && x == H_TOTAL-1 && y == V_DISPLAY-1. Exactly one pulse per frame.
- Reset (asynchronous, any time, including mid-frame):
  - tick counter = 0, x = 0, y = 0, hsync = 1, vsync = 1.
  - Consequently p_tick = 0 (with CLK_DIV > 1), video_on = 1, vblank_tick = 0.
  - Counting resumes from (0,0) on the first clk edge after reset deasserts.
- All widths are sized so that the parameter sums fit: x holds ≤ 2047, y holds ≤ 1023.

## Timing
- Pixel period: CLK_DIV clks.
- Line period: H_TOTAL*CLK_DIV = 3200 clks.
- Frame period: 3200*525 = 1,680,000 clks (≈59.5 Hz).
- x/y/video_on/hsync/vsync all change together on the clk edge that follows a p_tick cycle; they are stable for CLK_DIV clks.
- Downstream sprite ROMs are synchronous, adding 1 clk of read latency. Since x/y hold for 4 clks, pixel data settles within the same pixel period, so no compensation is needed in this block.
- Simultaneous wrap: at x = 799, y = 524 with p_tick, the next edge gives x = 0, y = 0, hsync = 1, vsync = 1.
- vblank_tick and p_tick coincide. vblank_tick precedes the y = 480 transition by one edge.

## Test plan
- Reset release: assert reset for 5 clks, release → x=0, y=0, hsync=1, vsync=1, video_on=1; first p_tick on the 4th clk edge after release (tick counter reaches 3); x=1 on the edge after that p_tick cycle.
- Pixel tick: free-run 400 clks → p_tick high exactly 100 times, always 4 clks apart; x never changes between ticks.
- Horizontal sync: observe one full line → hsync low for exactly 96 pixels (384 clks), first low at x=656, high again at x=752; video_on falls at x=640; x wraps 799→0 while y increments by 1.
- Vertical sync: run one full frame (1,680,000 clks) → vsync low only for y=490..491 (6400 clks); video_on low for all y ≥ 480; y wraps 524→0.
- vblank_tick: run two frames → exactly two pulses, each 1 clk wide, at x=799, y=479, spaced 1,680,000 clks apart.
- Mid-frame reset: assert reset asynchronously (between clk edges) at x=700, y=491 (hsync and vsync both low) → outputs return to reset values immediately, without waiting for a clk edge; after release, the timing sequence matches the reset-release scenario exactly.
